// File: rtl/core_mdu_pkg.sv
// rtl/core_mdu_pkg.sv - shared funct3 codes, FSM states and helpers for the MDU sequencer
package core_mdu_pkg;

  localparam logic [2:0] MDU_F3_MUL    = 3'b000;
  localparam logic [2:0] MDU_F3_MULH   = 3'b001;
  localparam logic [2:0] MDU_F3_MULHSU = 3'b010;
  localparam logic [2:0] MDU_F3_MULHU  = 3'b011;
  localparam logic [2:0] MDU_F3_DIV    = 3'b100;
  localparam logic [2:0] MDU_F3_DIVU   = 3'b101;
  localparam logic [2:0] MDU_F3_REM    = 3'b110;
  localparam logic [2:0] MDU_F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } mdu_seq_state_t;

  // The high-half multiplies have no *W form, so their word flag is meaningless.
  function automatic logic mdu_f3_has_word(input logic [2:0] f3);
    return !(f3 == MDU_F3_MULH || f3 == MDU_F3_MULHSU || f3 == MDU_F3_MULHU);
  endfunction

endpackage

// File: rtl/core_pipe_exec_mdu_cache.sv
// rtl/core_pipe_exec_mdu_cache.sv - one-entry MDU result cache with operand compare
module core_pipe_exec_mdu_cache
  import core_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [2:0]      wr_funct3,
  input  logic            wr_word,
  input  logic [XLEN-1:0] wr_rs1,
  input  logic [XLEN-1:0] wr_rs2,
  input  logic [XLEN-1:0] wr_rd,
  input  logic [2:0]      lk_funct3,
  input  logic            lk_word,
  input  logic [XLEN-1:0] lk_rs1,
  input  logic [XLEN-1:0] lk_rs2,
  output logic            hit,
  output logic [XLEN-1:0] hit_rd
);

  logic            valid_q;
  logic [2:0]      funct3_q;
  logic            word_q;
  logic [XLEN-1:0] rs1_q;
  logic [XLEN-1:0] rs2_q;
  logic [XLEN-1:0] rd_q;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      valid_q  <= 1'b0;
      funct3_q <= '0;
      word_q   <= 1'b0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (wr_en) begin
      valid_q  <= 1'b1;
      funct3_q <= wr_funct3;
      word_q   <= wr_word;
      rs1_q    <= wr_rs1;
      rs2_q    <= wr_rs2;
      rd_q     <= wr_rd;
    end
  end

  assign hit    = valid_q && (funct3_q == lk_funct3) && (word_q == lk_word) &&
                  (rs1_q == lk_rs1) && (rs2_q == lk_rs2);
  assign hit_rd = rd_q;

endmodule

// File: rtl/core_pipe_exec_mdu_seq.sv
// rtl/core_pipe_exec_mdu_seq.sv - uop sequencer and result buffer in front of the MDU (optional MDU_SEQ_RESULT_CACHE_EN)
module core_pipe_exec_mdu_seq
  import core_mdu_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int XL  = XLEN - 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [2:0]  s_funct3,
  input  logic        s_word,
  input  logic [XL:0] s_rs1,
  input  logic [XL:0] s_rs2,
  input  logic [4:0]  s_rd_addr,
  output logic        mdu_valid,
  output logic        mdu_flush,
  output logic        mdu_op_word,
  output logic        mdu_op_mul,
  output logic        mdu_op_mulh,
  output logic        mdu_op_mulhu,
  output logic        mdu_op_mulhsu,
  output logic        mdu_op_div,
  output logic        mdu_op_divu,
  output logic        mdu_op_rem,
  output logic        mdu_op_remu,
  output logic [XL:0] mdu_rs1,
  output logic [XL:0] mdu_rs2,
  input  logic        mdu_ready,
  input  logic [XL:0] mdu_rd,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [4:0]  m_rd_addr,
  output logic [XL:0] m_rd_data
);

  mdu_seq_state_t state_q, state_d;

  logic [2:0]  f3_q;
  logic        word_q;
  logic [XL:0] rs1_q;
  logic [XL:0] rs2_q;
  logic [4:0]  rd_addr_q;

  logic        accept;
  logic        load_mdu;
  logic        load_cache;
  logic        cache_hit;
  logic [XL:0] cache_rd;
  logic        s_word_eff;

  assign s_word_eff = s_word && mdu_f3_has_word(s_funct3);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    accept     = 1'b0;
    load_mdu   = 1'b0;
    load_cache = 1'b0;
    mdu_valid  = 1'b0;
    mdu_flush  = flush;
    unique case (state_q)
      IDLE: begin
        s_ready    = !flush && (!m_valid || m_ready);
        accept     = s_valid && s_ready;
        load_cache = accept && cache_hit;
        if (accept && !cache_hit) state_d = RUN;
      end
      RUN: begin
        mdu_valid = 1'b1;
        if (mdu_ready && !flush) begin
          load_mdu = 1'b1;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        mdu_flush = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // The MDU only ever sees these registers, never the live s_* inputs.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      f3_q      <= '0;
      word_q    <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_addr_q <= '0;
    end else if (accept) begin
      f3_q      <= s_funct3;
      word_q    <= s_word_eff;
      rs1_q     <= s_rs1;
      rs2_q     <= s_rs2;
      rd_addr_q <= s_rd_addr;
    end
  end

  assign mdu_rs1 = rs1_q;
  assign mdu_rs2 = rs2_q;

  always_comb begin
    mdu_op_word   = 1'b0;
    mdu_op_mul    = 1'b0;
    mdu_op_mulh   = 1'b0;
    mdu_op_mulhsu = 1'b0;
    mdu_op_mulhu  = 1'b0;
    mdu_op_div    = 1'b0;
    mdu_op_divu   = 1'b0;
    mdu_op_rem    = 1'b0;
    mdu_op_remu   = 1'b0;
    if (state_q == RUN) begin
      mdu_op_word = word_q;
      unique case (f3_q)
        MDU_F3_MUL:    mdu_op_mul    = 1'b1;
        MDU_F3_MULH:   mdu_op_mulh   = 1'b1;
        MDU_F3_MULHSU: mdu_op_mulhsu = 1'b1;
        MDU_F3_MULHU:  mdu_op_mulhu  = 1'b1;
        MDU_F3_DIV:    mdu_op_div    = 1'b1;
        MDU_F3_DIVU:   mdu_op_divu   = 1'b1;
        MDU_F3_REM:    mdu_op_rem    = 1'b1;
        MDU_F3_REMU:   mdu_op_remu   = 1'b1;
        default:       mdu_op_mul    = 1'b0;
      endcase
    end
  end

  // A reload wins over a drain in the same cycle so back-to-back results are never dropped.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      m_valid   <= 1'b0;
      m_rd_data <= '0;
      m_rd_addr <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (load_mdu) begin
      m_valid   <= 1'b1;
      m_rd_data <= mdu_rd;
      m_rd_addr <= rd_addr_q;
    end else if (load_cache) begin
      m_valid   <= 1'b1;
      m_rd_data <= cache_rd;
      m_rd_addr <= s_rd_addr;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef MDU_SEQ_RESULT_CACHE_EN
  core_pipe_exec_mdu_cache #(
    .XLEN(XLEN)
  ) u_cache (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .wr_en     (load_mdu),
    .wr_funct3 (f3_q),
    .wr_word   (word_q),
    .wr_rs1    (rs1_q),
    .wr_rs2    (rs2_q),
    .wr_rd     (mdu_rd),
    .lk_funct3 (s_funct3),
    .lk_word   (s_word_eff),
    .lk_rs1    (s_rs1),
    .lk_rs2    (s_rs2),
    .hit       (cache_hit),
    .hit_rd    (cache_rd)
  );
`else
  assign cache_hit = 1'b0;
  assign cache_rd  = '0;
`endif

endmodule

// File: tb/tb_core_pipe_exec_mdu_seq.sv
// tb/tb_core_pipe_exec_mdu_seq.sv - randomized scoreboard bench with behavioural MDU for core_pipe_exec_mdu_seq
module tb_core_pipe_exec_mdu_seq;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [2:0]  s_funct3 = '0;
  logic        s_word = 1'b0;
  logic [63:0] s_rs1 = '0;
  logic [63:0] s_rs2 = '0;
  logic [4:0]  s_rd_addr = '0;
  logic        mdu_valid, mdu_flush, mdu_op_word;
  logic        mdu_op_mul, mdu_op_mulh, mdu_op_mulhu, mdu_op_mulhsu;
  logic        mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu;
  logic [63:0] mdu_rs1, mdu_rs2;
  logic        mdu_ready = 1'b0;
  logic [63:0] mdu_rd = '0;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_rd_addr;
  logic [63:0] m_rd_data;

  logic rand_bp = 1'b0;
  logic bp_rand = 1'b1;
  logic m_ready_fixed = 1'b0;
  assign m_ready = rand_bp ? bp_rand : m_ready_fixed;

  always #5 g_clk = ~g_clk;

  core_pipe_exec_mdu_seq #(.XLEN(64)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_funct3(s_funct3), .s_word(s_word),
    .s_rs1(s_rs1), .s_rs2(s_rs2), .s_rd_addr(s_rd_addr),
    .mdu_valid(mdu_valid), .mdu_flush(mdu_flush), .mdu_op_word(mdu_op_word),
    .mdu_op_mul(mdu_op_mul), .mdu_op_mulh(mdu_op_mulh), .mdu_op_mulhu(mdu_op_mulhu),
    .mdu_op_mulhsu(mdu_op_mulhsu), .mdu_op_div(mdu_op_div), .mdu_op_divu(mdu_op_divu),
    .mdu_op_rem(mdu_op_rem), .mdu_op_remu(mdu_op_remu),
    .mdu_rs1(mdu_rs1), .mdu_rs2(mdu_rs2), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd_addr(m_rd_addr), .m_rd_data(m_rd_data)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics, straight from the ISA rules.
  function automatic logic [63:0] ref_m(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0]  a32, b32, r32;
    logic [63:0]  r;
    logic [127:0] ea, eb, p;
    a32 = a[31:0];
    b32 = b[31:0];
    r32 = '0;
    r   = '0;
    if (w && !(f3 inside {3'd1, 3'd2, 3'd3})) begin
      case (f3)
        3'd0: r32 = a32 * b32;
        3'd4: begin
          if (b32 == 0) r32 = 32'hFFFF_FFFF;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
          else r32 = $signed(a32) / $signed(b32);
        end
        3'd5: begin
          if (b32 == 0) r32 = 32'hFFFF_FFFF;
          else r32 = a32 / b32;
        end
        3'd6: begin
          if (b32 == 0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 32'd0;
          else r32 = $signed(a32) % $signed(b32);
        end
        default: begin
          if (b32 == 0) r32 = a32;
          else r32 = a32 % b32;
        end
      endcase
      return {{32{r32[31]}}, r32};
    end
    ea = (f3 == 3'd1 || f3 == 3'd2) ? {{64{a[63]}}, a} : {64'd0, a};
    eb = (f3 == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    case (f3)
      3'd0: r = a * b;
      3'd1, 3'd2, 3'd3: r = p[127:64];
      3'd4: begin
        if (b == 0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 0) r = '1;
        else r = a / b;
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
        else r = $signed(a) % $signed(b);
      end
      default: begin
        if (b == 0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  // Behavioural MDU: decodes the one-hot lines, random latency, sticky done until mdu_flush.
  logic [7:0] ops;
  assign ops = {mdu_op_mul, mdu_op_mulh, mdu_op_mulhsu, mdu_op_mulhu,
                mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu};

  logic [2:0] dec_f3;
  always_comb begin
    dec_f3 = 3'd0;
    if (mdu_op_mulh)   dec_f3 = 3'd1;
    if (mdu_op_mulhsu) dec_f3 = 3'd2;
    if (mdu_op_mulhu)  dec_f3 = 3'd3;
    if (mdu_op_div)    dec_f3 = 3'd4;
    if (mdu_op_divu)   dec_f3 = 3'd5;
    if (mdu_op_rem)    dec_f3 = 3'd6;
    if (mdu_op_remu)   dec_f3 = 3'd7;
  end

  int          lat_force = -1;
  logic        mdl_busy = 1'b0;
  int          mdl_cnt = 0;
  logic [2:0]  mdl_f3 = '0;
  logic        mdl_word = 1'b0;
  logic [63:0] mdl_a = '0;
  logic [63:0] mdl_b = '0;

  always @(posedge g_clk) begin
    if (!g_resetn || mdu_flush) begin
      mdl_busy  <= 1'b0;
      mdu_ready <= 1'b0;
    end else if (mdu_valid && !mdu_ready) begin
      if (!mdl_busy) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
        mdl_f3   <= dec_f3;
        mdl_word <= mdu_op_word;
        mdl_a    <= mdu_rs1;
        mdl_b    <= mdu_rs2;
      end else if (mdl_cnt == 0) begin
        mdu_ready <= 1'b1;
        mdu_rd    <= ref_m(mdl_f3, mdl_word, mdl_a, mdl_b);
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge g_clk);
      #1;
      bp_rand = ($urandom_range(0, 3) != 0);
    end
  end

  // Scoreboard: {rd_addr, data}
  logic [68:0] exp_q[$];
  int          flush_cyc = 0;
  int          xfers = 0;
  logic        prev_mv = 1'b0;
  logic        prev_hold = 1'b0;
  logic [7:0]  saved_ops = '0;
  logic        saved_word = 1'b0;
  logic [63:0] saved_rs1 = '0, saved_rs2 = '0, saved_data = '0;
  logic [4:0]  saved_addr = '0;

  always @(negedge g_clk) begin
    if (g_resetn) begin
      if (mdu_valid) begin
        check("op_onehot", 64'($countones(ops)), 64'd1);
        if (mdu_op_mulh || mdu_op_mulhsu || mdu_op_mulhu)
          check("op_word_forced_low", 64'(mdu_op_word), 64'd0);
        if (prev_mv) begin
          check("op_stable", 64'({saved_word, saved_ops}), 64'({mdu_op_word, ops}));
          check("rs1_stable", mdu_rs1, saved_rs1);
          check("rs2_stable", mdu_rs2, saved_rs2);
        end
        saved_ops  = ops;
        saved_word = mdu_op_word;
        saved_rs1  = mdu_rs1;
        saved_rs2  = mdu_rs2;
      end else begin
        check("op_lines_idle", 64'({mdu_op_word, ops}), 64'd0);
      end
      prev_mv = mdu_valid;
      if (mdu_flush) flush_cyc++;
      if (prev_hold && !flush) begin
        check("hold_m_valid", 64'(m_valid), 64'd1);
        check("hold_data", m_rd_data, saved_data);
        check("hold_addr", 64'(m_rd_addr), 64'(saved_addr));
      end
      prev_hold  = m_valid && !m_ready;
      saved_data = m_rd_data;
      saved_addr = m_rd_addr;
      if (m_valid && m_ready && !flush) begin
        logic [68:0] item;
        xfers++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got addr %0d data %h expected no result", m_rd_addr, m_rd_data);
        end else begin
          item = exp_q.pop_front();
          check("wb_data", m_rd_data, item[63:0]);
          check("wb_addr", 64'(m_rd_addr), 64'(item[68:64]));
        end
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd, input bit expect_it);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1; s_funct3 = f3; s_word = w; s_rs1 = a; s_rs2 = b; s_rd_addr = rd;
    for (int i = 0; i < 200; i++) begin
      @(negedge g_clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && expect_it) exp_q.push_back({rd, ref_m(f3, w, a, b)});
    if (!ok) check("issue_timeout", 64'd0, 64'd1);
    @(posedge g_clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge g_clk);
      if (exp_q.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge g_clk);
    #1;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'd1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'h0000_0000_8000_0000;
      5: return 64'(32'hFFFF_FFFF);
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0, x0;
    repeat (3) @(posedge g_clk);
    #1;
    g_resetn = 1'b1;
    @(negedge g_clk);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_mdu_valid", 64'(mdu_valid), 64'd0);
    check("rst_mdu_flush", 64'(mdu_flush), 64'd0);
    check("rst_op_lines", 64'({mdu_op_word, ops}), 64'd0);
    check("rst_m_rd_data", m_rd_data, 64'd0);
    check("rst_m_rd_addr", 64'(m_rd_addr), 64'd0);
    check("rst_mdu_rs1", mdu_rs1, 64'd0);
    check("rst_mdu_rs2", mdu_rs2, 64'd0);
    @(posedge g_clk);
    #1;
    m_ready_fixed = 1'b1;

    // MUL 6*7
    f0 = flush_cyc;
    x0 = xfers;
    issue(3'd0, 1'b0, 64'd6, 64'd7, 5'd5, 1'b1);
    @(negedge g_clk);
    check("mdu_valid_after_accept", 64'(mdu_valid), 64'd1);
    @(posedge g_clk);
    #1;
    wait_drain();
    check("mul_result_value", ref_m(3'd0, 1'b0, 64'd6, 64'd7), 64'd42);
    check("mul_flush_pulses", 64'(flush_cyc - f0), 64'd1);
    check("mul_m_valid_pulses", 64'(xfers - x0), 64'd1);

    // DIVU then REM back-to-back, then *W corner cases
    issue(3'd5, 1'b0, 64'd100, 64'd7, 5'd1, 1'b1);
    issue(3'd6, 1'b0, -64'sd7, 64'd2, 5'd2, 1'b1);
    issue(3'd4, 1'b1, 64'd1, 64'd0, 5'd3, 1'b1);
    issue(3'd0, 1'b1, 64'h8000_0000, 64'd2, 5'd4, 1'b1);
    wait_drain();

    // Backpressure: result held, s_ready low, then drain and accept in the same cycle
    m_ready_fixed = 1'b0;
    issue(3'd0, 1'b0, 64'd11, 64'd3, 5'd7, 1'b1);
    for (int i = 0; i < 50 && !m_valid; i++) @(negedge g_clk);
    check("bp_result_arrived", 64'(m_valid), 64'd1);
    @(posedge g_clk);
    #1;
    s_valid = 1'b1; s_funct3 = 3'd4; s_word = 1'b0; s_rs1 = 64'd50; s_rs2 = 64'd5; s_rd_addr = 5'd8;
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      check("bp_s_ready_low", 64'(s_ready), 64'd0);
      check("bp_data_held", m_rd_data, 64'd33);
      @(posedge g_clk);
      #1;
    end
    m_ready_fixed = 1'b1;
    @(negedge g_clk);
    check("bp_accept_same_cycle", 64'(s_ready), 64'd1);
    if (s_ready) exp_q.push_back({5'd8, ref_m(3'd4, 1'b0, 64'd50, 64'd5)});
    @(posedge g_clk);
    #1;
    s_valid = 1'b0;
    wait_drain();

    // Flush mid-RUN on a long DIV
    lat_force = 8;
    issue(3'd4, 1'b0, 64'd100, 64'd3, 5'd9, 1'b0);
    repeat (2) @(posedge g_clk);
    #1;
    flush = 1'b1;
    s_valid = 1'b1; s_funct3 = 3'd0; s_rs1 = 64'd1; s_rs2 = 64'd1; s_rd_addr = 5'd20;
    @(negedge g_clk);
    check("flush_mdu_flush", 64'(mdu_flush), 64'd1);
    check("flush_s_ready", 64'(s_ready), 64'd0);
    @(posedge g_clk);
    #1;
    flush = 1'b0;
    s_valid = 1'b0;
    @(negedge g_clk);
    check("flush_no_mdu_valid", 64'(mdu_valid), 64'd0);
    check("flush_idle_s_ready", 64'(s_ready), 64'd1);
    check("flush_no_m_valid", 64'(m_valid), 64'd0);
    lat_force = -1;
    repeat (5) @(negedge g_clk);
    check("flush_still_no_m_valid", 64'(m_valid), 64'd0);
    @(posedge g_clk);
    #1;
    issue(3'd0, 1'b0, 64'd3, 64'd3, 5'd10, 1'b1);
    wait_drain();

    // Randomized ops under random backpressure
    rand_bp = 1'b1;
    for (int n = 0; n < 150; n++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
            5'($urandom_range(0, 31)), 1'b1);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge g_clk);
        #1;
      end
    end
    wait_drain();
    rand_bp = 1'b0;

`ifdef MDU_SEQ_RESULT_CACHE_EN
    issue(3'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_1234_5678, 5'd11, 1'b1);
    wait_drain();
    issue(3'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_1234_5678, 5'd12, 1'b1);
    @(negedge g_clk);
    check("cache_hit_latency", 64'(m_valid), 64'd1);
    check("cache_hit_no_mdu_valid", 64'(mdu_valid), 64'd0);
    @(posedge g_clk);
    #1;
    wait_drain();
    flush = 1'b1;
    @(posedge g_clk);
    #1;
    flush = 1'b0;
    issue(3'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_0000_1234_5678, 5'd13, 1'b1);
    @(negedge g_clk);
    check("cache_miss_after_flush", 64'(mdu_valid), 64'd1);
    @(posedge g_clk);
    #1;
    wait_drain();
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
